// File: rtl/dmem_sram_bridge_if.sv
// Bundle of CPU data-memory request/response and single-port SRAM signals.
// The bridge uses the slave modport; the CPU/SRAM environment uses master.
interface dmem_sram_bridge_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  dmem_req_valid;
    logic                  dmem_req_we;
    logic [31:0]           dmem_req_addr;
    logic [31:0]           dmem_req_data;
    logic                  dmem_req_size_0;
    logic                  dmem_req_size_1;
    logic                  dmem_req_ready;
    logic                  dmem_resp_valid;
    logic [31:0]           dmem_resp_data;
    logic                  mem_gnt;
    logic                  mem_en;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  misalign_err;
    logic [31:0]           load_count;
    logic [31:0]           store_count;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
               dmem_req_size_0, dmem_req_size_1, mem_gnt, mem_rdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data, mem_en, mem_we,
               mem_be, mem_addr, mem_wdata, misalign_err, load_count, store_count
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
               dmem_req_size_0, dmem_req_size_1, mem_gnt, mem_rdata,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data, mem_en, mem_we,
               mem_be, mem_addr, mem_wdata, misalign_err, load_count, store_count
    );
endinterface

// File: rtl/dmem_sram_bridge.sv
// Bridge from the CPU data-memory port to a single-port synchronous SRAM:
// byte-lane steering, misalignment drop, load alignment and event counters.
module dmem_sram_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_LAT    = 1
) (
    input  logic               clock,
    input  logic               reset,
    dmem_sram_bridge_if.slave  bus
);
    logic [1:0]         w_size;
    logic [1:0]         w_off;
    logic               w_accept;
    logic               w_aligned;
    logic               w_issue;
    logic [31:0]        w_shifted;
    logic [31:0]        w_resp_data;
    logic               w_unused;

    logic [MEM_LAT-1:0] r_pipe_v;
    logic [1:0]         r_pipe_off  [MEM_LAT];
    logic [1:0]         r_pipe_size [MEM_LAT];
    logic               r_resp_valid;
    logic [31:0]        r_resp_data;
    logic               r_err;
    logic [31:0]        r_load_count;
    logic [31:0]        r_store_count;

    assign w_size   = {bus.dmem_req_size_1, bus.dmem_req_size_0};
    assign w_off    = bus.dmem_req_addr[1:0];
    assign w_unused = ^bus.dmem_req_addr[31:ADDR_WIDTH+2];

    assign bus.dmem_req_ready = bus.mem_gnt && !reset;
    assign w_accept           = bus.dmem_req_valid && bus.dmem_req_ready;

    always_comb begin
        case (w_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = !w_off[0];
            2'b10:   w_aligned = (w_off == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    // Misaligned/illegal requests are consumed by the handshake but never reach the SRAM.
    assign w_issue      = w_accept && w_aligned;
    assign bus.mem_en   = w_issue;
    assign bus.mem_we   = w_issue && bus.dmem_req_we;
    assign bus.mem_addr = bus.dmem_req_addr[ADDR_WIDTH+1:2];

    always_comb begin
        bus.mem_be    = 4'b1111;
        bus.mem_wdata = bus.dmem_req_data;
        if (bus.dmem_req_we) begin
            case (w_size)
                2'b00: begin
                    bus.mem_be    = 4'b0001 << w_off;
                    bus.mem_wdata = {4{bus.dmem_req_data[7:0]}};
                end
                2'b01: begin
                    bus.mem_be    = 4'b0011 << w_off;
                    bus.mem_wdata = {2{bus.dmem_req_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v[0] <= w_issue && !bus.dmem_req_we;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        r_pipe_off[0]  <= w_off;
        r_pipe_size[0] <= w_size;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            r_pipe_off[i]  <= r_pipe_off[i-1];
            r_pipe_size[i] <= r_pipe_size[i-1];
        end
    end

    assign w_shifted = bus.mem_rdata >> {r_pipe_off[MEM_LAT-1], 3'b000};

    always_comb begin
        case (r_pipe_size[MEM_LAT-1])
            2'b00:   w_resp_data = {24'h000000, w_shifted[7:0]};
            2'b01:   w_resp_data = {16'h0000, w_shifted[15:0]};
            default: w_resp_data = w_shifted;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_err         <= 1'b0;
            r_load_count  <= '0;
            r_store_count <= '0;
        end else begin
            r_resp_valid <= r_pipe_v[MEM_LAT-1];
            if (r_pipe_v[MEM_LAT-1]) begin
                r_resp_data <= w_resp_data;
            end
            if (w_accept && !w_aligned) begin
                r_err <= 1'b1;
            end
            if (w_issue) begin
                if (bus.dmem_req_we) begin
                    r_store_count <= r_store_count + 32'd1;
                end else begin
                    r_load_count <= r_load_count + 32'd1;
                end
            end
        end
    end

    assign bus.dmem_resp_valid = r_resp_valid;
    assign bus.dmem_resp_data  = r_resp_data;
    assign bus.misalign_err    = r_err;
    assign bus.load_count      = r_load_count;
    assign bus.store_count     = r_store_count;
endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: three DUTs (MEM_LAT 1..3) share one request
// stream; each has its own SRAM model and checks responses against a shared scoreboard.
module tb_dmem_sram_bridge;
    localparam int AW = 12;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_data  = '0;
    logic [1:0]  req_size  = '0;
    logic        gnt       = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ref_mem [2**AW];
    int          exp_lc  = 0;
    int          exp_sc  = 0;
    logic        exp_err = 1'b0;

    logic        ready_a [NI];
    logic        en_a    [NI];
    logic        we_a    [NI];
    logic        rv_a    [NI];
    logic        err_a   [NI];
    logic [3:0]  be_a    [NI];
    logic [AW-1:0] addr_a [NI];
    logic [31:0] wdata_a [NI];
    logic [31:0] rdata_a [NI];
    logic [31:0] lc_a    [NI];
    logic [31:0] sc_a    [NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = g + 1;
        dmem_sram_bridge_if #(.ADDR_WIDTH(AW)) bus ();
        logic [31:0] sram    [2**AW];
        logic [31:0] rd_pipe [LAT];
        int          rd_idx = 0;

        assign bus.dmem_req_valid  = req_valid;
        assign bus.dmem_req_we     = req_we;
        assign bus.dmem_req_addr   = req_addr;
        assign bus.dmem_req_data   = req_data;
        assign bus.dmem_req_size_0 = req_size[0];
        assign bus.dmem_req_size_1 = req_size[1];
        assign bus.mem_gnt         = gnt;
        assign bus.mem_rdata       = rd_pipe[LAT-1];

        assign ready_a[g] = bus.dmem_req_ready;
        assign en_a[g]    = bus.mem_en;
        assign we_a[g]    = bus.mem_we;
        assign rv_a[g]    = bus.dmem_resp_valid;
        assign err_a[g]   = bus.misalign_err;
        assign be_a[g]    = bus.mem_be;
        assign addr_a[g]  = bus.mem_addr;
        assign wdata_a[g] = bus.mem_wdata;
        assign rdata_a[g] = bus.dmem_resp_data;
        assign lc_a[g]    = bus.load_count;
        assign sc_a[g]    = bus.store_count;

        dmem_sram_bridge #(.ADDR_WIDTH(AW), .MEM_LAT(LAT)) dut (
            .clock (clk),
            .reset (rst),
            .bus   (bus.slave)
        );

        // SRAM model: byte-masked writes, reads delayed by LAT registers
        always @(posedge clk) begin
            if (bus.mem_en) begin
                if (bus.mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                    end
                end else begin
                    rd_pipe[0] <= sram[bus.mem_addr];
                end
            end
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end

        always @(negedge clk) begin
            if (bus.dmem_resp_valid) begin
                if (rd_idx < sb.size()) begin
                    chk($sformatf("resp_data_lat%0d", LAT), bus.dmem_resp_data, sb[rd_idx].data);
                    chk($sformatf("resp_cycle_lat%0d", LAT), cyc, sb[rd_idx].cyc + LAT);
                    rd_idx++;
                end else begin
                    chk($sformatf("resp_unexpected_lat%0d", LAT), {31'b0, bus.dmem_resp_valid}, 32'd0);
                end
            end
            if (rst) rd_idx = sb.size();
        end
    end

    function automatic logic req_aligned(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd0) || (s == 2'd1 && a[0] == 1'b0) || (s == 2'd2 && a[1:0] == 2'd0);
    endfunction

    // Drive one request with gnt=1; checks SRAM-side signals and updates the reference model.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size);
        logic        al;
        int          o;
        int          nb;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] w;
        logic [31:0] ed;
        exp_t        e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        al = req_aligned(addr, size);
        o  = int'(addr[1:0]);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        ebe = '0;
        for (int b = 0; b < 4; b++) if (!we || (b >= o && b < o + nb)) ebe[b] = 1'b1;
        ewd = (size == 2'd0) ? {data[7:0], data[7:0], data[7:0], data[7:0]} :
              (size == 2'd1) ? {data[15:0], data[15:0]} : data;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("req_ready", {31'b0, ready_a[g]}, 32'd1);
            chk("mem_en", {31'b0, en_a[g]}, {31'b0, al});
            if (al) begin
                chk("mem_we", {31'b0, we_a[g]}, {31'b0, we});
                chk("mem_addr", {20'b0, addr_a[g]}, {20'b0, addr[AW+1:2]});
                chk("mem_be", {28'b0, be_a[g]}, {28'b0, ebe});
                if (we) chk("mem_wdata", wdata_a[g], ewd);
            end
        end
        if (!al) begin
            exp_err = 1'b1;
        end else if (we) begin
            w = ref_mem[addr[AW+1:2]];
            for (int b = 0; b < nb; b++) w[8*(o+b) +: 8] = data[8*b +: 8];
            ref_mem[addr[AW+1:2]] = w;
            exp_sc++;
        end else begin
            w  = ref_mem[addr[AW+1:2]];
            ed = '0;
            for (int b = 0; b < nb; b++) ed[8*b +: 8] = w[8*(o+b) +: 8];
            e.data = ed;
            e.cyc  = cyc + 1;
            sb.push_back(e);
            exp_lc++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk({tag, "_load_count"}, lc_a[g], exp_lc);
            chk({tag, "_store_count"}, sc_a[g], exp_sc);
            chk({tag, "_misalign_err"}, {31'b0, err_a[g]}, {31'b0, exp_err});
        end
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (g_inst[0].rd_idx == sb.size() && g_inst[1].rd_idx == sb.size() &&
                g_inst[2].rd_idx == sb.size()) break;
        end
        chk({tag, "_pending_lat1"}, sb.size() - g_inst[0].rd_idx, 32'd0);
        chk({tag, "_pending_lat2"}, sb.size() - g_inst[1].rd_idx, 32'd0);
        chk({tag, "_pending_lat3"}, sb.size() - g_inst[2].rd_idx, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk({tag, "_ready"}, {31'b0, ready_a[g]}, 32'd0);
            chk({tag, "_mem_en"}, {31'b0, en_a[g]}, 32'd0);
            chk({tag, "_mem_we"}, {31'b0, we_a[g]}, 32'd0);
            chk({tag, "_resp_valid"}, {31'b0, rv_a[g]}, 32'd0);
            chk({tag, "_resp_data"}, rdata_a[g], 32'd0);
            chk({tag, "_misalign_err"}, {31'b0, err_a[g]}, 32'd0);
            chk({tag, "_load_count"}, lc_a[g], 32'd0);
            chk({tag, "_store_count"}, sc_a[g], 32'd0);
        end
    endtask

    initial begin
        int          wd;
        logic [1:0]  sz;
        logic [31:0] a;

        // Reset with gnt and a store request present: nothing must leak through
        gnt = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;

        // Word store then load to the same word, back to back
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2);
        do_req(1'b0, 32'h10, 32'h0, 2'd2);
        drain("word_rt");
        chk_state("word_rt");
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk("resp_data_hold", rdata_a[g], 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Byte store into lane 3, then word/half/byte loads
        do_req(1'b1, 32'h13, 32'h000000A5, 2'd0);
        do_req(1'b0, 32'h10, 32'h0, 2'd2);
        do_req(1'b0, 32'h12, 32'h0, 2'd1);
        do_req(1'b0, 32'h11, 32'h0, 2'd0);
        drain("byte_lane");

        // Mixed widths on another word
        do_req(1'b1, 32'h20, 32'h11223344, 2'd2);
        do_req(1'b1, 32'h22, 32'h0000CAFE, 2'd1);
        do_req(1'b1, 32'h20, 32'h0000005A, 2'd0);
        do_req(1'b0, 32'h23, 32'h0, 2'd0);
        do_req(1'b0, 32'h20, 32'h0, 2'd1);
        do_req(1'b0, 32'h20, 32'h0, 2'd2);
        drain("mixed");

        // Four back-to-back loads
        do_req(1'b0, 32'h10, 32'h0, 2'd2);
        do_req(1'b0, 32'h20, 32'h0, 2'd2);
        do_req(1'b0, 32'h12, 32'h0, 2'd1);
        do_req(1'b0, 32'h21, 32'h0, 2'd0);
        drain("b2b");
        chk_state("b2b");

        // Random aligned traffic over 16 initialised words
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'h40 + 4 * i, $urandom, 2'd2);
        for (int i = 0; i < 60; i++) begin
            wd = $urandom_range(0, 15);
            sz = 2'($urandom_range(0, 2));
            a  = 32'h40 + 4 * wd;
            if (sz == 2'd0) a = a + $urandom_range(0, 3);
            if (sz == 2'd1) a = a + 2 * $urandom_range(0, 1);
            do_req(1'($urandom_range(0, 1)), a, $urandom, sz);
        end
        drain("random");
        chk_state("random");

        // Misaligned half, illegal size, misaligned word: dropped, sticky error
        do_req(1'b0, 32'h11, 32'h0, 2'd1);
        chk_state("misalign_half");
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 2'd3);
        do_req(1'b0, 32'h22, 32'h0, 2'd2);
        drain("misalign");
        chk_state("misalign");
        do_req(1'b0, 32'h20, 32'h0, 2'd2);
        drain("after_misalign");

        // Grant withheld for 3 cycles with a load in flight
        do_req(1'b0, 32'h10, 32'h0, 2'd2);
        gnt = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                chk("nognt_ready", {31'b0, ready_a[g]}, 32'd0);
                chk("nognt_mem_en", {31'b0, en_a[g]}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        gnt = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 2'd2);
        drain("nognt");
        chk_state("nognt");

        // Reset one cycle after a load accept; the earlier store must persist
        do_req(1'b1, 32'h30, 32'h0BADF00D, 2'd2);
        do_req(1'b0, 32'h30, 32'h0, 2'd2);
        rst = 1'b1;
        exp_lc = 0; exp_sc = 0; exp_err = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk_state("post_reset");
        do_req(1'b0, 32'h30, 32'h0, 2'd2);
        drain("post_reset_load");
        chk_state("post_reset_load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
- Sits directly downstream of the CPU core's data-memory port.
- Accepts dmem_req_* requests and drives a single-port synchronous SRAM with a fixed read latency.
- Produces byte enables and shifted store data, and aligns load data into dmem_resp_data.
- Detects misaligned accesses and drops them, and provides load/store event counters.

Parameters:
- ADDR_WIDTH, 12: SRAM word-address width. The SRAM is 2^ADDR_WIDTH words of 32 bits.
- MEM_LAT, 1: SRAM read latency in cycles, legal range 1..3.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dmem_req_valid  in  1  request valid from CPU
- dmem_req_we  in  1  1 = store, 0 = load
- dmem_req_addr  in  32  byte address
- dmem_req_data  in  32  store data, right-justified
- dmem_req_size_0  in  1  size bit 0
- dmem_req_size_1  in  1  size bit 1; {size_1,size_0}: 00 = byte, 01 = half, 10 = word, 11 = illegal
- dmem_req_ready  out  1  bridge accepts a request this cycle
- dmem_resp_valid  out  1  load response valid, one-cycle pulse
- dmem_resp_data  out  32  load data, right-justified, zero-extended
- mem_gnt  in  1  SRAM port granted to the data side this cycle
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_be  out  4  SRAM byte enables
- mem_addr  out  ADDR_WIDTH  SRAM word address = dmem_req_addr[ADDR_WIDTH+1:2]
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid MEM_LAT cycles after a read
- misalign_err  out  1  sticky flag: a misaligned or illegal-size request was dropped
- load_count  out  32  accepted loads, wrapping
- store_count  out  32  accepted stores, wrapping

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high.
- Reset values:
  - dmem_resp_valid = 0, dmem_resp_data = 0, misalign_err = 0, load_count = 0, store_count = 0.
  - Latency pipeline cleared to all-invalid.
  - mem_en and mem_we are 0 while reset is high.
- Handshake:
  - dmem_req_ready = mem_gnt && !reset. It is purely combinational, with no dependence on dmem_req_valid.
  - A request is accepted when dmem_req_valid && dmem_req_ready.
  - The SRAM access is issued in the same cycle as acceptance: mem_en = accept && aligned, mem_we = dmem_req_we.
- Alignment:
  - Half requires addr[0] = 0. Word requires addr[1:0] = 0. Size 11 is illegal.
  - A misaligned or illegal request is still accepted (ready is unaffected), but:
    - no SRAM access is made, no response is produced, counters do not change;
    - misalign_err is set the next cycle and held until reset.
- Store byte enables, with o = addr[1:0]:
  - byte: mem_be = 0001 << o, mem_wdata = {4{data[7:0]}}.
  - half: mem_be = 0011 << o, mem_wdata = {2{data[15:0]}}.
  - word: mem_be = 1111, mem_wdata = data.
- Loads:
  - mem_be = 1111 on every read.
  - Stores produce no response.
- Latency pipeline:
  - MEM_LAT stages, each holding {valid, offset[1:0], size[1:0]}, shifted every cycle regardless of mem_gnt.
  - At the final stage, the result is registered: dmem_resp_valid <= stage valid, and dmem_resp_data <= (mem_rdata >> 8*offset) masked to 8/16/32 bits per size.
  - Total load latency: the response is visible MEM_LAT+1 cycles after the accept edge.
  - One load may be accepted per cycle; back-to-back responses are returned in order with no gaps.
- Ordering:
  - In-order single port. A load accepted the cycle after a store to the same word returns the post-store value, since SRAM write-first ordering is guaranteed by issue order.
- dmem_resp_data:
  - Holds its last value while dmem_resp_valid = 0.
- Counters:
  - load_count increments on each accepted aligned load; store_count on each accepted aligned store.
  - Both wrap 0xFFFFFFFF -> 0.
- Reset mid-operation:
  - In-flight loads are discarded and no response pulse appears after reset deasserts.
  - Stores issued before the reset edge are not retracted.
- mem_gnt low:
  - ready = 0, no accept, no SRAM enable.
  - In-flight loads still complete and respond on schedule.

Test Plan:
- Store word 0xDEADBEEF to addr 0x10, then load word from 0x10 (MEM_LAT=1) -> mem_be=1111, mem_addr=4; dmem_resp_valid pulses 2 cycles after the load accept with data 0xDEADBEEF; store_count=1, load_count=1.
- Store byte 0xA5 to addr 0x13, then load word 0x10 -> mem_be=1000, mem_wdata=0xA5A5A5A5; read returns 0xA5ADBEEF. Load half from 0x12 -> 0x0000A5AD. Load byte from 0x11 -> 0x000000BE.
- Four back-to-back loads with MEM_LAT=3 -> four consecutive resp_valid pulses starting 4 cycles after the first accept, data in issue order.
- Load half from 0x11, and a request with size 11 -> accepted (ready=1), mem_en=0, no response, misalign_err=1 from the next cycle until reset, counters unchanged.
- Hold mem_gnt=0 for 3 cycles with valid=1 while one load is in flight -> ready=0 and mem_en=0 for those 3 cycles; the in-flight load still responds on time; the new request is accepted on the first cycle mem_gnt=1.
- Assert reset one cycle after a load accept with MEM_LAT=2 -> no dmem_resp_valid pulse after reset; all outputs at their reset values; counters=0.
